gb_rotary_axil_poller: RTL and testbench
========================================

# gb_rotary_axil_poller

AXI4-Lite initiator that services the gb_rotary capture block without CPU involvement. On a level interrupt it reads the latched time stamp, clock counter and rotary position over AXI4-Lite, then writes the control register to clear the interrupt. It presents the three values as one record on a valid/ready output stream. It sits between the rotary capture slave and the data-logging stream path, and replaces the interrupt handler.

## Interface
- HOLDOFF, 2: cycles after the clear-write B handshake during which `interrupt` is ignored.
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset; asynchronous and active-low.
- interrupt  in  1  level interrupt from the capture slave (sync detected).
- enable  in  1  poller armed; sampled only in IDLE.
- z_en_cfg  in  1  value written to control bit 1 on every clear.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  4/3/1/1  write address channel; AWPROT = 0.
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel; WSTRB = 4'b0001.
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  4/3/1/1  read address channel; ARPROT = 0.
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- rec_time_stamp  out  32  value read from 0x8.
- rec_clk_counter  out  16  RDATA[15:0] read from 0xC.
- rec_rot_pos  out  32  value read from 0x0.
- rec_err  out  1  any RRESP/BRESP ≠ OKAY during this record's sequence.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, AR_TS, R_TS, AR_CC, R_CC, AR_POS, R_POS, WR_CLR, B_CLR, OUT, HOLD.
- IDLE → AR_TS when `enable && interrupt && holdoff_cnt==0`. Per-sequence error flag is cleared on this transition.
- Each AR_x state: ARVALID=1 with a constant ARADDR. Exit to R_x on ARVALID&&ARREADY.
- Each R_x state: RREADY=1. On RVALID, capture RDATA into the record register and OR (RRESP≠0) into the error flag. Then go to the next AR state; from R_POS go to WR_CLR.
- WR_CLR: AWVALID and WVALID asserted in the same cycle. AWADDR=0x4, WDATA={30'b0, z_en_cfg, 1'b0}. Each valid drops independently on its own ready. Go to B_CLR once both have been accepted, in the same or different cycles.
- B_CLR: BREADY=1. On BVALID, OR (BRESP≠0) into the error flag, load holdoff_cnt=HOLDOFF, go to OUT.
- OUT: rec_valid=1; record fields and rec_err stable. On rec_ready → HOLD.
- HOLD → IDLE. holdoff_cnt decrements every cycle while nonzero, in any state.
- Error responses do not abort the sequence; the record is still emitted with rec_err=1.
- `enable` deasserting mid-sequence has no effect until IDLE.
- `interrupt` is not sampled outside IDLE. A sync arriving during OUT is serviced after return to IDLE.
- Never more than one outstanding AXI transaction.
- Reset (asynchronous): state=IDLE. All AXI valids, RREADY, BREADY, rec_valid and rec_err = 0. Record fields = 0. holdoff_cnt=0. Addresses/data outputs = 0.
- Reset mid-transaction abandons it. The slave is reset by the same net.

## Timing
- All outputs are registered. AXI valids assert the cycle after entering their state.
- Each state advances the cycle after its handshake.
- Minimum latency from `interrupt` sampled high to rec_valid: 12 cycles when every ready/valid responds in one cycle.
- rec_valid falls the cycle after the rec_ready handshake.
- holdoff guarantees the slave's interrupt has deasserted before re-sampling; HOLDOFF≥2 is required.

## Structure
- Package gb_rotary_pkg: register offsets REG_POS=4'h0, REG_CTRL=4'h4, REG_TS=4'h8, REG_CC=4'hC; control bit indices CTRL_INTR=0, CTRL_ZEN=1; RESP_OKAY=2'b00; FSM state enum.
- One sub-module is natural: axil_single_master. It carries out one AXI4-Lite read or write per start pulse and returns done/data/resp. The poller FSM sequences it.

## Test plan
- Slave model with TS=0x0000_1234, CC=0xABCD, POS=0x0001_0000; interrupt pulsed high -> reads issued in order 0x8, 0xC, 0x0, then a write to 0x4 with WDATA=0x2 (z_en_cfg=1); record {0x1234, 0xABCD, 0x10000}, rec_err=0.
- Slave delays ARREADY/AWREADY/WREADY 3 cycles, and WREADY arrives before AWREADY -> valids are held stable until accepted; exactly one write occurs.
- Second read returns RRESP=2'b10 -> full sequence still completes; record emitted with rec_err=1; the next record has rec_err=0.
- rec_ready held low 20 cycles while interrupt re-asserts -> rec_valid held, no AXI traffic; the second sequence starts after HOLD.
- ARESETN asserted during R_CC -> all valids/readies 0 immediately; after release, IDLE with rec_valid=0.
- enable=0 with interrupt high -> no transactions and busy=0; enable=1 -> sequence starts.

Source files
------------

// File: rtl/gb_rotary_axil_poller_pkg.sv
// ---------------------------------------------------------------------------
// gb_rotary_pkg
// Shared definitions for the gb_rotary capture poller: register map of the
// rotary capture slave, control register bit positions, AXI response codes,
// the poller FSM state type and a helper that builds the clear word.
// No ports (package).
// ---------------------------------------------------------------------------
package gb_rotary_pkg;

    // Register offsets inside the rotary capture slave
    localparam logic [3:0] REG_POS  = 4'h0;
    localparam logic [3:0] REG_CTRL = 4'h4;
    localparam logic [3:0] REG_TS   = 4'h8;
    localparam logic [3:0] REG_CC   = 4'hC;

    // Control register bit indices
    localparam int CTRL_INTR = 0;
    localparam int CTRL_ZEN  = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        IDLE,
        AR_TS,
        R_TS,
        AR_CC,
        R_CC,
        AR_POS,
        R_POS,
        WR_CLR,
        B_CLR,
        OUT,
        HOLD
    } poller_state_e;

    // Writing zero to the interrupt bit clears it; the Z-enable bit is
    // rewritten with its configured value on every clear.
    function automatic logic [31:0] ctrl_clear_word(input logic z_en);
        logic [31:0] w;
        w            = '0;
        w[CTRL_ZEN]  = z_en;
        w[CTRL_INTR] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/gb_rotary_axil_poller_if.sv
// ---------------------------------------------------------------------------
// gb_rotary_axil_poller_if
// AXI4-Lite bus between the poller (master) and the rotary capture slave.
// master modport: drives AW/W/AR channels and BREADY/RREADY.
// slave modport : drives the ready signals and the B/R response channels.
// ---------------------------------------------------------------------------
interface gb_rotary_axil_poller_if;

    logic [3:0]  M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [3:0]  M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/gb_rotary_axil_poller_axil_single_master.sv
// ---------------------------------------------------------------------------
// axil_single_master
// Performs one AXI4-Lite read or write per start pulse; all bus outputs are
// flops. Only one transaction is ever in flight.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle request; is_write/addr/wdata qualify it
//   req_accepted   address phase done (AR accepted, or both AW and W accepted)
//   done           response handshake this cycle (R or B)
//   rdata, resp    read data and response code valid while done is high
//   axi            AXI4-Lite master side
// ---------------------------------------------------------------------------
module axil_single_master
    import gb_rotary_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_write,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        req_accepted,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  resp,
    gb_rotary_axil_poller_if.master axi
);

    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [3:0]  araddr_q, araddr_d;
    logic [3:0]  awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic aw_left, w_left, wr_issued, wr_accepted;

    assign ar_hs = arvalid_q & axi.M_AXI_ARREADY;
    assign r_hs  = rready_q  & axi.M_AXI_RVALID;
    assign aw_hs = awvalid_q & axi.M_AXI_AWREADY;
    assign w_hs  = wvalid_q  & axi.M_AXI_WREADY;
    assign b_hs  = bready_q  & axi.M_AXI_BVALID;

    // AW and W are accepted independently; the write address phase is over
    // on the cycle where neither valid will still be up afterwards.
    assign aw_left     = awvalid_q & ~axi.M_AXI_AWREADY;
    assign w_left      = wvalid_q  & ~axi.M_AXI_WREADY;
    assign wr_issued   = awvalid_q | wvalid_q;
    assign wr_accepted = wr_issued & ~aw_left & ~w_left;

    // Next-state for the channel valids/readies and the held address/data
    always_comb begin
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;

        if (start) begin
            if (is_write) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = addr;
                wdata_d   = wdata;
            end else begin
                arvalid_d = 1'b1;
                araddr_d  = addr;
            end
        end
        if (ar_hs) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
        end
        if (r_hs)        rready_d  = 1'b0;
        if (aw_hs)       awvalid_d = 1'b0;
        if (w_hs)        wvalid_d  = 1'b0;
        if (wr_accepted) bready_d  = 1'b1;
        if (b_hs)        bready_d  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign req_accepted = ar_hs | wr_accepted;
    assign done         = r_hs | b_hs;
    assign rdata        = axi.M_AXI_RDATA;
    assign resp         = bready_q ? axi.M_AXI_BRESP : axi.M_AXI_RRESP;

    assign axi.M_AXI_ARVALID = arvalid_q;
    assign axi.M_AXI_ARADDR  = araddr_q;
    assign axi.M_AXI_ARPROT  = 3'b000;
    assign axi.M_AXI_RREADY  = rready_q;
    assign axi.M_AXI_AWVALID = awvalid_q;
    assign axi.M_AXI_AWADDR  = awaddr_q;
    assign axi.M_AXI_AWPROT  = 3'b000;
    assign axi.M_AXI_WVALID  = wvalid_q;
    assign axi.M_AXI_WDATA   = wdata_q;
    assign axi.M_AXI_WSTRB   = 4'b0001;
    assign axi.M_AXI_BREADY  = bready_q;

endmodule

// File: rtl/gb_rotary_axil_poller.sv
// ---------------------------------------------------------------------------
// gb_rotary_axil_poller
// Services the rotary capture slave on interrupt: reads time stamp, clock
// counter and position, writes the control register to clear the interrupt,
// then offers the three values as one record on a valid/ready stream.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN  clock, asynchronous active-low reset
//   interrupt, enable          level interrupt, poller armed (IDLE only)
//   z_en_cfg                   Z-enable bit rewritten on every clear
//   m_axi                      AXI4-Lite master bus
//   rec_*                      record stream (valid/ready + fields + error)
//   busy                       sequence in progress
// ---------------------------------------------------------------------------
module gb_rotary_axil_poller
    import gb_rotary_pkg::*;
#(
    parameter int HOLDOFF = 2
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        interrupt,
    input  logic        enable,
    input  logic        z_en_cfg,
    gb_rotary_axil_poller_if.master m_axi,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] rec_time_stamp,
    output logic [15:0] rec_clk_counter,
    output logic [31:0] rec_rot_pos,
    output logic        rec_err,
    output logic        busy
);

    localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

    poller_state_e state_q, state_d;
    logic          start_q, start_d;
    logic          cmd_write_q, cmd_write_d;
    logic [3:0]    cmd_addr_q, cmd_addr_d;
    logic [31:0]   cmd_wdata_q, cmd_wdata_d;
    logic [HW-1:0] holdoff_q, holdoff_d;
    logic [31:0]   rec_ts_q, rec_ts_d;
    logic [15:0]   rec_cc_q, rec_cc_d;
    logic [31:0]   rec_pos_q, rec_pos_d;
    logic          err_q, err_d;
    logic          rec_valid_q, rec_valid_d;
    logic          busy_q, busy_d;

    logic          req_accepted, done;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    logic          resp_bad;

    axil_single_master u_master (
        .clk          (M_AXI_ACLK),
        .rst_n        (M_AXI_ARESETN),
        .start        (start_q),
        .is_write     (cmd_write_q),
        .addr         (cmd_addr_q),
        .wdata        (cmd_wdata_q),
        .req_accepted (req_accepted),
        .done         (done),
        .rdata        (rdata),
        .resp         (resp),
        .axi          (m_axi)
    );

    assign resp_bad = (resp != RESP_OKAY);

    // Sequencer: each AR/WR state fires a registered start, so the bus valid
    // comes up one cycle after the state is entered. Errors are accumulated
    // but never abort the sequence.
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        holdoff_d   = (holdoff_q != '0) ? holdoff_q - HW'(1) : holdoff_q;
        rec_ts_d    = rec_ts_q;
        rec_cc_d    = rec_cc_q;
        rec_pos_d   = rec_pos_q;
        err_d       = err_q;
        rec_valid_d = rec_valid_q;

        unique case (state_q)
            IDLE: if (enable && interrupt && holdoff_q == '0) begin
                state_d     = AR_TS;
                err_d       = 1'b0;
                start_d     = 1'b1;
                cmd_write_d = 1'b0;
                cmd_addr_d  = REG_TS;
            end
            AR_TS:  if (req_accepted) state_d = R_TS;
            R_TS: if (done) begin
                rec_ts_d   = rdata;
                err_d      = err_q | resp_bad;
                state_d    = AR_CC;
                start_d    = 1'b1;
                cmd_addr_d = REG_CC;
            end
            AR_CC:  if (req_accepted) state_d = R_CC;
            R_CC: if (done) begin
                rec_cc_d   = rdata[15:0];
                err_d      = err_q | resp_bad;
                state_d    = AR_POS;
                start_d    = 1'b1;
                cmd_addr_d = REG_POS;
            end
            AR_POS: if (req_accepted) state_d = R_POS;
            R_POS: if (done) begin
                rec_pos_d   = rdata;
                err_d       = err_q | resp_bad;
                state_d     = WR_CLR;
                start_d     = 1'b1;
                cmd_write_d = 1'b1;
                cmd_addr_d  = REG_CTRL;
                cmd_wdata_d = ctrl_clear_word(z_en_cfg);
            end
            WR_CLR: if (req_accepted) state_d = B_CLR;
            B_CLR: if (done) begin
                err_d       = err_q | resp_bad;
                holdoff_d   = HW'(HOLDOFF);
                state_d     = OUT;
                rec_valid_d = 1'b1;
            end
            OUT: if (rec_ready) begin
                state_d     = HOLD;
                rec_valid_d = 1'b0;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            holdoff_q   <= '0;
            rec_ts_q    <= '0;
            rec_cc_q    <= '0;
            rec_pos_q   <= '0;
            err_q       <= 1'b0;
            rec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            holdoff_q   <= holdoff_d;
            rec_ts_q    <= rec_ts_d;
            rec_cc_q    <= rec_cc_d;
            rec_pos_q   <= rec_pos_d;
            err_q       <= err_d;
            rec_valid_q <= rec_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rec_valid       = rec_valid_q;
    assign rec_time_stamp  = rec_ts_q;
    assign rec_clk_counter = rec_cc_q;
    assign rec_rot_pos     = rec_pos_q;
    assign rec_err         = err_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_gb_rotary_axil_poller.sv
// ---------------------------------------------------------------------------
// tb_gb_rotary_axil_poller
// Directed bench for the rotary capture poller with a behavioural capture
// slave (configurable ready delays, injectable read error, interrupt latch
// set by a sync pulse and cleared by a control write with bit 0 low).
// ---------------------------------------------------------------------------
module tb_gb_rotary_axil_poller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, z_en_cfg, rec_ready;
    logic        rec_valid, rec_err, busy;
    logic [31:0] rec_time_stamp, rec_rot_pos;
    logic [15:0] rec_clk_counter;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model configuration and bookkeeping
    logic        irq_pulse;
    logic        intr_q;
    int          ar_wait, aw_wait, w_wait, err_read_idx;
    int          ar_cnt, aw_cnt, w_cnt;
    logic [31:0] slave_ts, slave_cc, slave_pos;
    int          read_count  = 0;
    int          write_count = 0;
    logic [3:0]  rd_log [64];
    logic [3:0]  last_awaddr;
    logic [31:0] last_wdata;
    logic        got_aw, got_w;
    logic [3:0]  aw_hold;
    logic [31:0] w_hold;
    int          viol_count = 0;

    gb_rotary_axil_poller_if axi_if ();

    gb_rotary_axil_poller #(.HOLDOFF(2)) dut (
        .M_AXI_ACLK      (clk),
        .M_AXI_ARESETN   (rst_n),
        .interrupt       (intr_q),
        .enable          (enable),
        .z_en_cfg        (z_en_cfg),
        .m_axi           (axi_if),
        .rec_valid       (rec_valid),
        .rec_ready       (rec_ready),
        .rec_time_stamp  (rec_time_stamp),
        .rec_clk_counter (rec_clk_counter),
        .rec_rot_pos     (rec_rot_pos),
        .rec_err         (rec_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Readies are granted once the valid has waited the configured cycles
    logic aw_hs, w_hs, aw_now, w_now;
    logic [31:0] rd_val, wdata_eff;
    logic [3:0]  awaddr_eff;
    assign axi_if.M_AXI_ARREADY = axi_if.M_AXI_ARVALID && (ar_cnt >= ar_wait);
    assign axi_if.M_AXI_AWREADY = axi_if.M_AXI_AWVALID && (aw_cnt >= aw_wait);
    assign axi_if.M_AXI_WREADY  = axi_if.M_AXI_WVALID  && (w_cnt  >= w_wait);
    assign aw_hs      = axi_if.M_AXI_AWVALID && axi_if.M_AXI_AWREADY;
    assign w_hs       = axi_if.M_AXI_WVALID  && axi_if.M_AXI_WREADY;
    assign aw_now     = got_aw || aw_hs;
    assign w_now      = got_w  || w_hs;
    assign wdata_eff  = got_w  ? w_hold  : axi_if.M_AXI_WDATA;
    assign awaddr_eff = got_aw ? aw_hold : axi_if.M_AXI_AWADDR;
    assign rd_val = (axi_if.M_AXI_ARADDR == 4'h8) ? slave_ts  :
                    (axi_if.M_AXI_ARADDR == 4'hC) ? slave_cc  :
                    (axi_if.M_AXI_ARADDR == 4'h0) ? slave_pos : 32'h0;

    // Capture slave: shares the poller reset net
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi_if.M_AXI_RVALID <= 1'b0;
            axi_if.M_AXI_RDATA  <= '0;
            axi_if.M_AXI_RRESP  <= 2'b00;
            axi_if.M_AXI_BVALID <= 1'b0;
            axi_if.M_AXI_BRESP  <= 2'b00;
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0;
            aw_hold <= '0; w_hold <= '0;
            intr_q <= 1'b0;
        end else begin
            if (irq_pulse) intr_q <= 1'b1;
            if (axi_if.M_AXI_ARVALID && axi_if.M_AXI_ARREADY) begin
                ar_cnt <= 0;
                axi_if.M_AXI_RVALID <= 1'b1;
                axi_if.M_AXI_RDATA  <= rd_val;
                axi_if.M_AXI_RRESP  <= (read_count == err_read_idx) ? 2'b10 : 2'b00;
                rd_log[read_count & 63] <= axi_if.M_AXI_ARADDR;
                read_count <= read_count + 1;
            end else if (axi_if.M_AXI_ARVALID) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (axi_if.M_AXI_RVALID && axi_if.M_AXI_RREADY) axi_if.M_AXI_RVALID <= 1'b0;
            if (aw_hs) aw_cnt <= 0; else if (axi_if.M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
            if (w_hs)  w_cnt  <= 0; else if (axi_if.M_AXI_WVALID)  w_cnt  <= w_cnt + 1;
            if (aw_now && w_now) begin
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                axi_if.M_AXI_BVALID <= 1'b1;
                axi_if.M_AXI_BRESP  <= 2'b00;
                write_count <= write_count + 1;
                last_awaddr <= awaddr_eff;
                last_wdata  <= wdata_eff;
                if (awaddr_eff == 4'h4 && !wdata_eff[0]) intr_q <= 1'b0;
            end else begin
                if (aw_hs) begin got_aw <= 1'b1; aw_hold <= axi_if.M_AXI_AWADDR; end
                if (w_hs)  begin got_w  <= 1'b1; w_hold  <= axi_if.M_AXI_WDATA;  end
            end
            if (axi_if.M_AXI_BVALID && axi_if.M_AXI_BREADY) axi_if.M_AXI_BVALID <= 1'b0;
        end
    end

    // Pending valids must stay up with unchanged address/data
    logic        ar_pend_p, aw_pend_p, w_pend_p;
    logic [3:0]  araddr_p, awaddr_p;
    logic [31:0] wdata_p;
    always @(posedge clk) begin
        if (!rst_n) begin
            ar_pend_p <= 1'b0; aw_pend_p <= 1'b0; w_pend_p <= 1'b0;
        end else begin
            if (ar_pend_p && (!axi_if.M_AXI_ARVALID || axi_if.M_AXI_ARADDR != araddr_p)) viol_count <= viol_count + 1;
            if (aw_pend_p && (!axi_if.M_AXI_AWVALID || axi_if.M_AXI_AWADDR != awaddr_p)) viol_count <= viol_count + 1;
            if (w_pend_p  && (!axi_if.M_AXI_WVALID  || axi_if.M_AXI_WDATA  != wdata_p))  viol_count <= viol_count + 1;
            ar_pend_p <= axi_if.M_AXI_ARVALID && !axi_if.M_AXI_ARREADY;
            aw_pend_p <= axi_if.M_AXI_AWVALID && !axi_if.M_AXI_AWREADY;
            w_pend_p  <= axi_if.M_AXI_WVALID  && !axi_if.M_AXI_WREADY;
            araddr_p  <= axi_if.M_AXI_ARADDR;
            awaddr_p  <= axi_if.M_AXI_AWADDR;
            wdata_p   <= axi_if.M_AXI_WDATA;
        end
    end

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Sync pulse into the capture slave, which latches the interrupt level
    task automatic applyStimulus();
        irq_pulse = 1'b1;
        @(negedge clk);
        irq_pulse = 1'b0;
    endtask

    task automatic waitRecValid(input string tag, input int max_cycles, output int cycles);
        cycles = 0;
        while (!rec_valid && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, {31'b0, rec_valid}, 32'd1);
    endtask

    task automatic ackRecord();
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
    endtask

    initial begin
        int cyc, rc, wc, drops;
        logic found;

        rst_n = 1'b0; enable = 1'b0; z_en_cfg = 1'b0; rec_ready = 1'b0; irq_pulse = 1'b0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; err_read_idx = -1;
        slave_ts = 32'h0000_1234; slave_cc = 32'h0000_ABCD; slave_pos = 32'h0001_0000;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_busy",    {31'b0, busy}, 32'd0);
        checkOutput("rst_rvalid",  {31'b0, rec_valid}, 32'd0);
        checkOutput("rst_err",     {31'b0, rec_err}, 32'd0);
        checkOutput("rst_arvalid", {31'b0, axi_if.M_AXI_ARVALID}, 32'd0);
        checkOutput("rst_awvalid", {31'b0, axi_if.M_AXI_AWVALID}, 32'd0);
        checkOutput("rst_ts",      rec_time_stamp, 32'd0);
        checkOutput("rst_pos",     rec_rot_pos, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic sequence, zero wait");
        enable = 1'b1; z_en_cfg = 1'b1;
        rc = read_count; wc = write_count;
        applyStimulus();
        waitRecValid("t1_seen", 100, cyc);
        // one cycle to be sampled by IDLE, then 12 cycles to rec_valid
        checkOutput("t1_latency", cyc, 32'd13);
        checkOutput("t1_ts",  rec_time_stamp, 32'h0000_1234);
        checkOutput("t1_cc",  {16'b0, rec_clk_counter}, 32'h0000_ABCD);
        checkOutput("t1_pos", rec_rot_pos, 32'h0001_0000);
        checkOutput("t1_err", {31'b0, rec_err}, 32'd0);
        checkOutput("t1_rd0", {28'b0, rd_log[rc & 63]}, 32'h8);
        checkOutput("t1_rd1", {28'b0, rd_log[(rc + 1) & 63]}, 32'hC);
        checkOutput("t1_rd2", {28'b0, rd_log[(rc + 2) & 63]}, 32'h0);
        checkOutput("t1_nwr", write_count - wc, 32'd1);
        checkOutput("t1_awaddr", {28'b0, last_awaddr}, 32'h4);
        checkOutput("t1_wdata", last_wdata, 32'h2);
        checkOutput("t1_busy_out", {31'b0, busy}, 32'd1);
        ackRecord();
        checkOutput("t1_valid_fall", {31'b0, rec_valid}, 32'd0);
        @(negedge clk);
        checkOutput("t1_idle", {31'b0, busy}, 32'd0);
        repeat (4) @(negedge clk);

        $display("[TB] delayed readies, W before AW");
        ar_wait = 3; w_wait = 3; aw_wait = 5; z_en_cfg = 1'b0;
        slave_ts = 32'hDEAD_BEEF; slave_cc = 32'h7777_5555; slave_pos = 32'h8000_0001;
        rc = read_count; wc = write_count;
        applyStimulus();
        waitRecValid("t2_seen", 300, cyc);
        checkOutput("t2_ts",  rec_time_stamp, 32'hDEAD_BEEF);
        checkOutput("t2_cc",  {16'b0, rec_clk_counter}, 32'h0000_5555);
        checkOutput("t2_pos", rec_rot_pos, 32'h8000_0001);
        checkOutput("t2_nrd", read_count - rc, 32'd3);
        checkOutput("t2_nwr", write_count - wc, 32'd1);
        checkOutput("t2_wdata", last_wdata, 32'h0);
        checkOutput("t2_stable", viol_count, 32'd0);
        ackRecord();
        repeat (6) @(negedge clk);
        checkOutput("t2_nwr_after", write_count - wc, 32'd1);
        ar_wait = 0; w_wait = 0; aw_wait = 0;

        $display("[TB] error response on second read");
        z_en_cfg = 1'b1;
        slave_ts = 32'h11; slave_cc = 32'h22; slave_pos = 32'h33;
        err_read_idx = read_count + 1;
        wc = write_count;
        applyStimulus();
        waitRecValid("t3_seen", 100, cyc);
        checkOutput("t3_err", {31'b0, rec_err}, 32'd1);
        checkOutput("t3_cc",  {16'b0, rec_clk_counter}, 32'h22);
        checkOutput("t3_pos", rec_rot_pos, 32'h33);
        checkOutput("t3_nwr", write_count - wc, 32'd1);
        ackRecord();
        repeat (4) @(negedge clk);
        err_read_idx = -1;
        applyStimulus();
        waitRecValid("t3b_seen", 100, cyc);
        checkOutput("t3b_err", {31'b0, rec_err}, 32'd0);
        checkOutput("t3b_ts",  rec_time_stamp, 32'h11);
        ackRecord();
        repeat (4) @(negedge clk);

        $display("[TB] back-pressure with interrupt re-asserted");
        slave_ts = 32'hA5A5_A5A5;
        applyStimulus();
        waitRecValid("t4_seen", 100, cyc);
        rc = read_count; wc = write_count;
        applyStimulus();
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rec_valid) drops++;
        end
        checkOutput("t4_held", drops, 32'd0);
        checkOutput("t4_no_rd", read_count - rc, 32'd0);
        checkOutput("t4_no_wr", write_count - wc, 32'd0);
        ackRecord();
        checkOutput("t4_hold_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("t4_idle", {31'b0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("t4_restart", {31'b0, busy}, 32'd1);
        waitRecValid("t4b_seen", 100, cyc);
        checkOutput("t4b_ts",  rec_time_stamp, 32'hA5A5_A5A5);
        checkOutput("t4b_nrd", read_count - rc, 32'd3);
        ackRecord();
        repeat (4) @(negedge clk);

        $display("[TB] reset during R_CC");
        applyStimulus();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (axi_if.M_AXI_RREADY && axi_if.M_AXI_ARADDR == 4'hC) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("t5_reach_rcc", {31'b0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rready",  {31'b0, axi_if.M_AXI_RREADY}, 32'd0);
        checkOutput("t5_arvalid", {31'b0, axi_if.M_AXI_ARVALID}, 32'd0);
        checkOutput("t5_araddr",  {28'b0, axi_if.M_AXI_ARADDR}, 32'd0);
        checkOutput("t5_busy",    {31'b0, busy}, 32'd0);
        checkOutput("t5_ts",      rec_time_stamp, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t5_post_valid", {31'b0, rec_valid}, 32'd0);
        checkOutput("t5_post_busy",  {31'b0, busy}, 32'd0);

        $display("[TB] enable gating");
        enable = 1'b0;
        slave_pos = 32'h0000_BEEF;
        rc = read_count;
        applyStimulus();
        repeat (10) @(negedge clk);
        checkOutput("t6_busy", {31'b0, busy}, 32'd0);
        checkOutput("t6_no_rd", read_count - rc, 32'd0);
        enable = 1'b1;
        waitRecValid("t6_seen", 100, cyc);
        checkOutput("t6_pos", rec_rot_pos, 32'h0000_BEEF);
        checkOutput("t6_nrd", read_count - rc, 32'd3);
        ackRecord();
        repeat (4) @(negedge clk);

        checkOutput("final_stable", viol_count, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
